// File: rtl/wav_record_buffer.sv
// rtl/wav_record_buffer.sv - WAV sample FIFO between audio capture and the SD sector writer
// Samples are byte-swapped to WAV little-endian order on entry and handed out one word per read request.
module wav_record_buffer #(
   parameter int          DEPTH_LOG2   = 8,
   parameter int unsigned SECTOR_WORDS = 128
) (
   input  logic                  clock_50M,
   input  logic                  reset,
   input  logic                  record_en,
   input  logic [31:0]           wav_in_data,
   input  logic                  wav_wren,
   input  logic                  rd_req,
   output logic [31:0]           rd_data,
   output logic                  rd_valid,
   output logic                  sector_rdy,
   output logic [DEPTH_LOG2:0]   fill_level,
   output logic                  overflow,
   output logic [31:0]           sample_cnt,
   output logic [1:0]            state
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RECORD = 2'b01,
      DRAIN  = 2'b10
   } state_t;

   state_t                  cur_state, next_state;
   logic [31:0]             mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]     fill_next;
   logic                    full, rd_accept, wr_accept, drop, start;

   // fill_level never exceeds the depth, so its MSB alone marks full
   assign full      = fill_level[DEPTH_LOG2];
   assign rd_accept = rd_req && (fill_level != '0);
   assign wr_accept = wav_wren && (cur_state == RECORD) && (!full || rd_accept);
   assign drop      = wav_wren && (cur_state == RECORD) && !wr_accept;

   always_comb begin
      fill_next = fill_level;
      if (wr_accept && !rd_accept)
         fill_next = fill_level + (DEPTH_LOG2+1)'(1);
      else if (rd_accept && !wr_accept)
         fill_next = fill_level - (DEPTH_LOG2+1)'(1);
   end

   // Exit decisions use the post-cycle count so a word written on the exit cycle is drained, not stranded
   always_comb begin
      next_state = cur_state;
      start      = 1'b0;
      case (cur_state)
         IDLE: begin
            if (record_en) begin
               next_state = RECORD;
               start      = 1'b1;
            end
         end
         RECORD: begin
            if (!record_en)
               next_state = (fill_next != '0) ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (fill_next == '0)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock_50M) begin
      if (wr_accept)
         mem[wr_ptr] <= {wav_in_data[23:16], wav_in_data[31:24],
                         wav_in_data[7:0],   wav_in_data[15:8]};
   end

   always_ff @(posedge clock_50M) begin
      if (reset) begin
         cur_state  <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         overflow   <= 1'b0;
         sample_cnt <= '0;
      end else begin
         cur_state  <= next_state;
         fill_level <= fill_next;
         rd_valid   <= rd_accept;
         if (wr_accept)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_accept) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr];
         end
         if (start)
            overflow <= 1'b0;
         else if (drop)
            overflow <= 1'b1;
         if (start)
            sample_cnt <= '0;
         else if (wr_accept && (sample_cnt != '1))
            sample_cnt <= sample_cnt + 32'd1;
      end
   end

   assign sector_rdy = (32'(fill_level) >= SECTOR_WORDS) ||
                       ((cur_state == DRAIN) && (fill_level != '0));
   assign state      = cur_state;

endmodule

// File: tb/tb_wav_record_buffer.sv
// tb/tb_wav_record_buffer.sv - bench for wav_record_buffer
// Constant vector table, directed corner sequences and random traffic against a queue-based model.
module tb_wav_record_buffer;

   logic        clk = 1'b0;
   logic        reset = 1'b1, record_en = 1'b0, wav_wren = 1'b0, rd_req = 1'b0;
   logic [31:0] wav_in_data = '0;
   logic [31:0] rd_data, sample_cnt;
   logic        rd_valid, sector_rdy, overflow;
   logic [8:0]  fill_level;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   wav_record_buffer #(.DEPTH_LOG2(8), .SECTOR_WORDS(128)) dut (
      .clock_50M(clk), .reset(reset), .record_en(record_en), .wav_in_data(wav_in_data),
      .wav_wren(wav_wren), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
      .sector_rdy(sector_rdy), .fill_level(fill_level), .overflow(overflow),
      .sample_cnt(sample_cnt), .state(state)
   );

   always #5 clk = ~clk;

   // Reference model: the FIFO is a plain queue of already byte-swapped words
   bit [31:0] m_q[$];
   int        m_state = 0;
   bit        m_ovf = 0, m_rv = 0;
   bit [31:0] m_rdata = 0, m_cnt = 0;

   function automatic bit [31:0] wav_order(input bit [31:0] d);
      bit [15:0] l = d[31:16];
      bit [15:0] r = d[15:0];
      return {l[7:0], l[15:8], r[7:0], r[15:8]};
   endfunction

   task automatic model_step(input bit rst, rec, wren, input bit [31:0] d, input bit rd);
      bit rd_ok, wr_ok;
      if (rst) begin
         m_q.delete();
         m_state = 0; m_ovf = 0; m_rv = 0; m_rdata = 0; m_cnt = 0;
         return;
      end
      rd_ok = rd && (m_q.size() > 0);
      wr_ok = wren && (m_state == 1) && ((m_q.size() < 256) || rd_ok);
      if (wren && m_state == 1 && !wr_ok) m_ovf = 1;
      m_rv = rd_ok;
      if (rd_ok) m_rdata = m_q.pop_front();
      if (wr_ok) begin
         m_q.push_back(wav_order(d));
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
      case (m_state)
         0: if (rec) begin m_state = 1; m_cnt = 0; m_ovf = 0; end
         1: if (!rec) m_state = (m_q.size() != 0) ? 2 : 0;
         default: if (m_q.size() == 0) m_state = 0;
      endcase
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      bit exp_sector = (m_q.size() >= 128) || (m_state == 2 && m_q.size() != 0);
      chk("rd_valid",   32'(rd_valid),   32'(m_rv));
      chk("rd_data",    rd_data,         m_rdata);
      chk("fill_level", 32'(fill_level), 32'(m_q.size()));
      chk("sector_rdy", 32'(sector_rdy), 32'(exp_sector));
      chk("overflow",   32'(overflow),   32'(m_ovf));
      chk("sample_cnt", sample_cnt,      m_cnt);
      chk("state",      32'(state),      32'(m_state));
   endtask

   task automatic apply(input logic rst, rec, wren, input logic [31:0] d, input logic rd);
      reset = rst; record_en = rec; wav_wren = wren; wav_in_data = d; rd_req = rd;
      @(posedge clk);
      model_step(rst, rec, wren, d, rd);
      #1;
      compare_model();
   endtask

   typedef struct {
      logic        rst, rec, wren;
      logic [31:0] d;
      logic        rd;
      logic [1:0]  e_state;
      int          e_fill;
      logic        e_rv;
      logic [31:0] e_rdata;
      logic [31:0] e_cnt;
      logic        e_ovf;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{1, 0, 0, 32'h0,         0, 2'd0, 0, 0, 32'h0,         32'd0, 0};
      vecs[1]  = '{0, 1, 0, 32'h0,         0, 2'd1, 0, 0, 32'h0,         32'd0, 0};
      vecs[2]  = '{0, 1, 1, 32'h1234_ABCD, 0, 2'd1, 1, 0, 32'h0,         32'd1, 0};
      vecs[3]  = '{0, 1, 0, 32'h0,         1, 2'd1, 0, 1, 32'h3412_CDAB, 32'd1, 0};
      vecs[4]  = '{0, 1, 0, 32'h0,         1, 2'd1, 0, 0, 32'h3412_CDAB, 32'd1, 0};
      vecs[5]  = '{0, 1, 1, 32'h8001_7FFE, 0, 2'd1, 1, 0, 32'h3412_CDAB, 32'd2, 0};
      vecs[6]  = '{0, 0, 1, 32'hAABB_CCDD, 0, 2'd2, 2, 0, 32'h3412_CDAB, 32'd3, 0};
      vecs[7]  = '{0, 1, 0, 32'h0,         1, 2'd2, 1, 1, 32'h0180_FE7F, 32'd3, 0};
      vecs[8]  = '{0, 1, 1, 32'h5555_6666, 1, 2'd0, 0, 1, 32'hBBAA_DDCC, 32'd3, 0};
      vecs[9]  = '{0, 1, 0, 32'h0,         0, 2'd1, 0, 0, 32'hBBAA_DDCC, 32'd0, 0};
      vecs[10] = '{1, 1, 1, 32'hFFFF_0000, 1, 2'd0, 0, 0, 32'h0,         32'd0, 0};

      apply(1, 0, 0, 0, 0);
      for (int i = 0; i < 11; i++) begin
         apply(vecs[i].rst, vecs[i].rec, vecs[i].wren, vecs[i].d, vecs[i].rd);
         chk($sformatf("vec%0d_state", i), 32'(state),      32'(vecs[i].e_state));
         chk($sformatf("vec%0d_fill", i),  32'(fill_level), 32'(vecs[i].e_fill));
         chk($sformatf("vec%0d_rv", i),    32'(rd_valid),   32'(vecs[i].e_rv));
         chk($sformatf("vec%0d_rdata", i), rd_data,         vecs[i].e_rdata);
         chk($sformatf("vec%0d_cnt", i),   sample_cnt,      vecs[i].e_cnt);
         chk($sformatf("vec%0d_ovf", i),   32'(overflow),   32'(vecs[i].e_ovf));
      end

      // Sector threshold
      apply(1, 0, 0, 0, 0);
      apply(0, 1, 0, 0, 0);
      for (int i = 0; i < 127; i++) apply(0, 1, 1, $urandom, 0);
      chk("sector_at_127", 32'(sector_rdy), 32'd0);
      apply(0, 1, 1, $urandom, 0);
      chk("sector_at_128", 32'(sector_rdy), 32'd1);
      for (int i = 0; i < 128; i++) apply(0, 1, 0, 0, 1);
      chk("sector_after_reads", 32'(sector_rdy), 32'd0);
      chk("fill_after_reads",   32'(fill_level), 32'd0);

      // Overflow, then full with simultaneous read and write
      apply(1, 0, 0, 0, 0);
      apply(0, 1, 0, 0, 0);
      for (int i = 0; i < 256; i++) apply(0, 1, 1, 32'h0100_0203 + 32'(i), 0);
      chk("ovf_before_drop", 32'(overflow), 32'd0);
      apply(0, 1, 1, 32'hDEAD_BEEF, 0);
      chk("ovf_fill", 32'(fill_level), 32'd256);
      chk("ovf_cnt",  sample_cnt,      32'd256);
      chk("ovf_flag", 32'(overflow),   32'd1);
      apply(0, 1, 0, 0, 1);
      chk("ovf_first_word", rd_data, 32'h0001_0302);
      for (int i = 0; i < 4; i++) apply(0, 1, 1, 32'hCAFE_0000 + 32'(i), 1);
      chk("full_rw_fill", 32'(fill_level), 32'd255);

      // Simultaneous read/write at level 5, then a wrapping 300-word stream
      apply(1, 0, 0, 0, 0);
      apply(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) apply(0, 1, 1, $urandom, 0);
      apply(0, 1, 1, $urandom, 1);
      chk("rw_fill_5", 32'(fill_level), 32'd5);
      for (int i = 0; i < 300; i++) apply(0, 1, 1, $urandom, 1);
      chk("stream_fill_5", 32'(fill_level), 32'd5);

      // Drain
      apply(1, 0, 0, 0, 0);
      apply(0, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) apply(0, 1, 1, $urandom, 0);
      apply(0, 0, 0, 0, 0);
      chk("drain_state",  32'(state),      32'd2);
      chk("drain_sector", 32'(sector_rdy), 32'd1);
      for (int i = 0; i < 10; i++) apply(0, 1, 0, 0, 1);
      chk("drain_done_state",  32'(state),      32'd0);
      chk("drain_done_sector", 32'(sector_rdy), 32'd0);
      apply(0, 1, 0, 0, 0);
      chk("restart_state", 32'(state), 32'd1);

      // Reset mid-operation
      for (int i = 0; i < 50; i++) apply(0, 1, 1, $urandom, 0);
      apply(1, 1, 1, $urandom, 1);
      chk("rst_fill",  32'(fill_level), 32'd0);
      chk("rst_rv",    32'(rd_valid),   32'd0);
      chk("rst_state", 32'(state),      32'd0);
      chk("rst_ovf",   32'(overflow),   32'd0);
      apply(0, 0, 0, 0, 1);
      chk("rst_no_read", 32'(rd_valid), 32'd0);

      // Random traffic in phases with varying read/write bias
      begin
         int  wp = 50, rp = 50;
         logic rec = 1'b1;
         for (int i = 0; i < 4000; i++) begin
            if (i % 300 == 0) begin
               wp = $urandom_range(10, 95);
               rp = $urandom_range(5, 90);
            end
            if ($urandom_range(0, 199) == 0) rec = ~rec;
            apply($urandom_range(0, 1499) == 0, rec, $urandom_range(0, 99) < wp,
                  $urandom, $urandom_range(0, 99) < rp);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
